signal_tx: RTL and testbench
============================

Name: signal_tx

Overview:
Transmit-side level driver for a filtered single-wire status line. Accepts level-change requests over a req/ack handshake and drives o_tx_sig. Every driven level is held for at least HOLD_TH sample ticks, so the far-end pulse filter always treats it as a genuine transition. Sits at the sender end of the same line that the pulse-filter block receives.

Parameters:
CNT_W, 10, width of the hold/glitch tick counter; must represent HOLD_TH.
HOLD_TH, CNT_W'(9), minimum ticks each level is held after a transition; set above the receiver UP_TH; must be >= 1.
GLT_W, CNT_W'(4), injected glitch width in ticks, used only with the optional feature; set inside the receiver [DN_TH, UP_TH] band; must be >= 1.
END_OF_LIST, 1, unused list terminator.

Ports:
i_clk  input  1  clock.
i_rst_n  input  1  asynchronous reset, active-low.
i_tick  input  1  sample strobe that paces hold counting; same rate as the receiver i_vld.
i_req  input  1  level-change request; held high until o_ack.
i_lvl  input  1  requested logical level; stable while i_req is high.
o_ack  output  1  one-cycle accept pulse.
o_busy  output  1  high while the line is in HOLD or GLITCH.
i_rtmon  input  1  output polarity select; 1 inverts the physical line.
i_inj  input  1  glitch-inject request (optional feature).
o_inj_ack  output  1  one-cycle glitch-accept pulse (optional feature).
o_tx_sig  output  1  registered physical line output.

Behaviour:
- Clock i_clk; reset i_rst_n is asynchronous and active-low.
- Reset values: state=IDLE, cur_lvl=0, cnt=0, o_ack=0, o_inj_ack=0, o_busy=0, o_tx_sig=0.
- Internal line = cur_lvl, except in GLITCH where it is ~cur_lvl.
- o_tx_sig is registered: i_rtmon ? ~line : line.
- i_rtmon takes effect at the next edge. It does not affect state or cnt.
- FSM states: IDLE, HOLD, GLITCH.
- IDLE, i_req=1, i_lvl!=cur_lvl:
  - at the next edge: cur_lvl<=i_lvl, cnt<=0, state->HOLD, o_ack=1 for one cycle.
- IDLE, i_req=1, i_lvl==cur_lvl:
  - o_ack=1 for one cycle; no transition; state stays IDLE.
- HOLD:
  - cnt increments on each cycle with i_tick=1.
  - When a tick brings cnt to HOLD_TH: state->IDLE and cnt<=0 at that same edge.
  - i_req is not acked while in HOLD; the requester stalls.
  - A request pending on the cycle HOLD exits is accepted on the first IDLE cycle.
- Latency: request sampled in IDLE at edge N gives o_ack high and cur_lvl updated after edge N, and o_tx_sig updated after edge N+1.
- After an ack, the requester drops i_req. A request still high on the cycle after o_ack is treated as a new request. For an equal level this gives a repeat no-op ack.
- Ticks are counted only in HOLD and GLITCH. i_tick=0 for any duration freezes cnt.
- o_busy = (state!=IDLE), combinational from the state register.
- Asynchronous reset mid-HOLD or mid-GLITCH returns everything to reset values immediately.
- cnt saturates and never wraps. Parameter check: HOLD_TH >= 1, GLT_W >= 1, both < 2^CNT_W, asserted under ASSERT_ON.

Optional Feature:
SIGNAL_TX_GLITCH_INJ_EN
- Defined:
  - In IDLE with i_inj=1 and i_req=0, the next edge gives state->GLITCH, cnt<=0, o_inj_ack=1 for one cycle. i_req wins when both are high.
  - GLITCH drives line=~cur_lvl. Ticks count to GLT_W.
  - On the tick reaching GLT_W: line returns to cur_lvl, state->HOLD, cnt<=0, so a full HOLD_TH follows.
  - The receiver filters the glitch; this exercises the far-end filter in system test.
- Not defined: i_inj is ignored, GLITCH is unreachable, o_inj_ack is tied 0. Ports remain.

Test Plan:
1. Reset assert, i_req=1 held -> o_tx_sig=0, o_ack=0, o_busy=0 during reset; first ack only after release.
2. HOLD_TH=9, i_tick=1 every cycle, req i_lvl=1 sampled at edge N -> o_ack pulse after N, o_tx_sig=1 after N+1, o_busy high 9 cycles. Second req i_lvl=0 raised after the ack -> stalled, acked on the first IDLE cycle, o_tx_sig=0 one cycle later.
3. Req i_lvl equal to cur_lvl -> single o_ack, o_busy stays 0, o_tx_sig unchanged.
4. i_tick every 3rd cycle, HOLD_TH=9 -> o_busy high exactly 9 ticks (~27 cycles). i_tick=0 for 50 cycles mid-hold -> o_busy stays high, cnt frozen.
5. i_rtmon=1, level 1 -> o_tx_sig=0. Toggle i_rtmon mid-HOLD -> o_tx_sig flips next cycle, hold duration unchanged. Reset mid-HOLD -> IDLE, o_tx_sig=0.
6. With SIGNAL_TX_GLITCH_INJ_EN, GLT_W=4, cur_lvl=0 -> o_inj_ack pulse, o_tx_sig=1 for exactly 4 ticks then 0, o_busy high 4+9 ticks. i_inj and i_req together -> request wins. Without the macro -> no output change, o_inj_ack=0.

Source files
------------

// File: rtl/signal_tx.sv
// signal_tx: transmit-side level driver for a filtered single-wire status line.
// Accepts level-change requests over a req/ack handshake and holds every new
// level for at least HOLD_TH sample ticks so the far-end pulse filter always
// sees a genuine transition.
// Optional glitch injection is enabled by defining SIGNAL_TX_GLITCH_INJ_EN.
module signal_tx #(
    parameter int             CNT_W       = 10,
    parameter logic [CNT_W-1:0] HOLD_TH   = CNT_W'(9),
    parameter logic [CNT_W-1:0] GLT_W     = CNT_W'(4),
    parameter int             END_OF_LIST = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_tick,
    input  logic i_req,
    input  logic i_lvl,
    output logic o_ack,
    output logic o_busy,
    input  logic i_rtmon,
    input  logic i_inj,
    output logic o_inj_ack,
    output logic o_tx_sig
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        GLITCH = 2'd2
    } state_t;

    state_t           state_reg;
    logic             cur_lvl_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic             line;
    logic [CNT_W-1:0] cnt_next;
    logic             inj_go;
    logic             unused_sig;

    // Glitch requests only reach the FSM when the feature is built in.
`ifdef SIGNAL_TX_GLITCH_INJ_EN
    assign inj_go = i_inj;
`else
    assign inj_go = 1'b0;
`endif

    // Terminator parameter and (in the default build) i_inj carry no logic.
    assign unused_sig = i_inj & (END_OF_LIST != 0);

    // Internal line level: inverted from the held level only while glitching.
    assign line = (state_reg == GLITCH) ? ~cur_lvl_reg : cur_lvl_reg;

    // Saturating increment so the counter can never wrap back to zero.
    assign cnt_next = (&cnt_reg) ? cnt_reg : cnt_reg + CNT_W'(1);

    // Busy whenever the line is being held or glitched.
    assign o_busy = (state_reg != IDLE);

    // Main FSM: handshake, hold/glitch tick counting and registered line output.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg   <= IDLE;
            cur_lvl_reg <= 1'b0;
            cnt_reg     <= '0;
            o_ack       <= 1'b0;
            o_inj_ack   <= 1'b0;
            o_tx_sig    <= 1'b0;
        end else begin
            o_ack     <= 1'b0;
            o_inj_ack <= 1'b0;
            // Polarity select applies one cycle later and never touches the FSM.
            o_tx_sig  <= i_rtmon ? ~line : line;
            case (state_reg)
                IDLE: begin
                    if (i_req) begin
                        // Equal-level requests are acked as no-ops.
                        o_ack <= 1'b1;
                        if (i_lvl != cur_lvl_reg) begin
                            cur_lvl_reg <= i_lvl;
                            cnt_reg     <= '0;
                            state_reg   <= HOLD;
                        end
                    end else if (inj_go) begin
                        o_inj_ack <= 1'b1;
                        cnt_reg   <= '0;
                        state_reg <= GLITCH;
                    end
                end
                HOLD: begin
                    if (i_tick) begin
                        if (cnt_next >= HOLD_TH) begin
                            cnt_reg   <= '0;
                            state_reg <= IDLE;
                        end else begin
                            cnt_reg <= cnt_next;
                        end
                    end
                end
                GLITCH: begin
                    // After the glitch a full hold follows before new requests.
                    if (i_tick) begin
                        if (cnt_next >= GLT_W) begin
                            cnt_reg   <= '0;
                            state_reg <= HOLD;
                        end else begin
                            cnt_reg <= cnt_next;
                        end
                    end
                end
                default: begin
                    cnt_reg   <= '0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

`ifdef ASSERT_ON
    // Zero-length hold or glitch would make the far end see a bare pulse.
    always @(posedge i_clk) begin
        assert ((HOLD_TH != '0) && (GLT_W != '0));
    end
`endif

endmodule

// File: tb/tb_signal_tx.sv
// Directed self-checking bench for signal_tx (default parameters).
module tb_signal_tx;

    logic i_clk = 1'b0;
    logic i_rst_n;
    logic i_tick;
    logic i_req;
    logic i_lvl;
    logic i_rtmon;
    logic i_inj;
    logic o_ack;
    logic o_busy;
    logic o_inj_ack;
    logic o_tx_sig;

    int tests = 0;
    int fails = 0;
    int tick_div = 1;
    int tick_k = 0;
    int cycles;
    int rem;
    int tx1;

    signal_tx dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_tick    (i_tick),
        .i_req     (i_req),
        .i_lvl     (i_lvl),
        .o_ack     (o_ack),
        .o_busy    (o_busy),
        .i_rtmon   (i_rtmon),
        .i_inj     (i_inj),
        .o_inj_ack (o_inj_ack),
        .o_tx_sig  (o_tx_sig)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge i_clk);
        #1;
        tick_k++;
        i_tick = (tick_div != 0) && ((tick_k % ((tick_div != 0) ? tick_div : 1)) == 0);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (o_busy && n < 100) begin
            step();
            n++;
        end
        check(tag, {31'd0, o_busy}, 32'd0);
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_tick  = 1'b1;
        i_req   = 1'b1;
        i_lvl   = 1'b1;
        i_rtmon = 1'b0;
        i_inj   = 1'b0;

        // 1. Reset held with a pending request
        step(); step(); step();
        check("rst_tx",   {31'd0, o_tx_sig}, 32'd0);
        check("rst_ack",  {31'd0, o_ack},    32'd0);
        check("rst_busy", {31'd0, o_busy},   32'd0);
        i_rst_n = 1'b1;

        // 2. First request (level 1), then a stalled request (level 0)
        step();
        check("t2_ack1",  {31'd0, o_ack},    32'd1);
        check("t2_busy1", {31'd0, o_busy},   32'd1);
        check("t2_tx_lag",{31'd0, o_tx_sig}, 32'd0);
        i_lvl = 1'b0;
        step();
        check("t2_ack_pulse", {31'd0, o_ack},    32'd0);
        check("t2_tx1",       {31'd0, o_tx_sig}, 32'd1);
        cycles = 2;
        for (int i = 0; i < 7; i++) begin
            step();
            if (o_busy && !o_ack) cycles++;
        end
        check("t2_busy_9", cycles, 32'd9);
        step();
        check("t2_idle_busy", {31'd0, o_busy}, 32'd0);
        check("t2_stall_ack", {31'd0, o_ack},  32'd0);
        step();
        check("t2_ack2",  {31'd0, o_ack},    32'd1);
        check("t2_tx_hold1", {31'd0, o_tx_sig}, 32'd1);
        i_req = 1'b0;
        step();
        check("t2_tx0",   {31'd0, o_tx_sig}, 32'd0);
        wait_idle("t2_idle_to");

        // 3. Equal-level request is a no-op ack
        i_req = 1'b1; i_lvl = 1'b0;
        step();
        check("t3_ack",  {31'd0, o_ack},  32'd1);
        check("t3_busy", {31'd0, o_busy}, 32'd0);
        i_req = 1'b0;
        step();
        check("t3_ack_off", {31'd0, o_ack},    32'd0);
        check("t3_tx",      {31'd0, o_tx_sig}, 32'd0);

        // 4a. Tick every third cycle: 9 ticks, first tick 4 edges after entry
        i_req = 1'b1; i_lvl = 1'b1;
        step();
        check("t4_ack", {31'd0, o_ack}, 32'd1);
        i_req = 1'b0;
        tick_div = 3; tick_k = 0; i_tick = 1'b0;
        cycles = 1;
        for (int i = 0; i < 200; i++) begin
            step();
            if (!o_busy) break;
            cycles++;
        end
        check("t4_slow_busy", cycles, 32'd28);

        // 4b. 4 ticks, 50-cycle freeze, then exactly 5 more ticks to finish
        tick_div = 1; i_tick = 1'b1;
        i_req = 1'b1; i_lvl = 1'b0;
        step();
        check("t4_ack_b", {31'd0, o_ack}, 32'd1);
        i_req = 1'b0;
        step(); step(); step(); step();
        tick_div = 0; i_tick = 1'b0;
        cycles = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (o_busy) cycles++;
        end
        check("t4_frozen", cycles, 32'd50);
        tick_div = 1; i_tick = 1'b1;
        rem = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            rem++;
            if (!o_busy) break;
        end
        check("t4_resume", rem, 32'd5);

        // 5. Polarity select, mid-hold toggle, reset mid-hold
        i_rtmon = 1'b1;
        step();
        check("t5_inv_idle", {31'd0, o_tx_sig}, 32'd1);
        i_req = 1'b1; i_lvl = 1'b1;
        step();
        check("t5_ack", {31'd0, o_ack}, 32'd1);
        i_req = 1'b0;
        step();
        check("t5_inv_lvl1", {31'd0, o_tx_sig}, 32'd0);
        step(); step();
        i_rtmon = 1'b0;
        step();
        check("t5_toggle", {31'd0, o_tx_sig}, 32'd1);
        rem = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            rem++;
            if (!o_busy) break;
        end
        check("t5_hold_len", rem, 32'd5);
        i_req = 1'b1; i_lvl = 1'b0;
        step();
        check("t5_ack2", {31'd0, o_ack}, 32'd1);
        i_req = 1'b0;
        step(); step();
        i_rst_n = 1'b0;
        #1;
        check("t5_rst_busy", {31'd0, o_busy},   32'd0);
        check("t5_rst_tx",   {31'd0, o_tx_sig}, 32'd0);
        check("t5_rst_ack",  {31'd0, o_ack},    32'd0);
        step();
        i_rst_n = 1'b1;
        i_req = 1'b1; i_lvl = 1'b0;
        step();
        check("t5_lvl_rst_ack",  {31'd0, o_ack},  32'd1);
        check("t5_lvl_rst_busy", {31'd0, o_busy}, 32'd0);
        i_req = 1'b0;
        step();
        check("t5_lvl_rst_tx", {31'd0, o_tx_sig}, 32'd0);

        // 6. Glitch injection
`ifdef SIGNAL_TX_GLITCH_INJ_EN
        i_inj = 1'b1;
        step();
        check("t6_inj_ack", {31'd0, o_inj_ack}, 32'd1);
        check("t6_busy",    {31'd0, o_busy},    32'd1);
        i_inj = 1'b0;
        cycles = 1; tx1 = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (i == 0) check("t6_inj_pulse", {31'd0, o_inj_ack}, 32'd0);
            if (o_tx_sig) tx1++;
            if (!o_busy) break;
            cycles++;
        end
        check("t6_glitch_w",  tx1,    32'd4);
        check("t6_busy_total",cycles, 32'd13);
        i_inj = 1'b1; i_req = 1'b1; i_lvl = 1'b1;
        step();
        check("t6_req_wins",  {31'd0, o_ack},     32'd1);
        check("t6_no_inj_ack",{31'd0, o_inj_ack}, 32'd0);
        i_inj = 1'b0; i_req = 1'b0;
        step();
        check("t6_req_tx", {31'd0, o_tx_sig}, 32'd1);
        wait_idle("t6_idle_to");
`else
        i_inj = 1'b1;
        cycles = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (o_inj_ack || o_busy || o_tx_sig) cycles++;
        end
        check("t6_inj_ignored", cycles, 32'd0);
        i_inj = 1'b0;
        i_req = 1'b1; i_lvl = 1'b1;
        step();
        check("t6_req_after_inj", {31'd0, o_ack}, 32'd1);
        i_req = 1'b0;
        step();
        check("t6_tx_after_inj", {31'd0, o_tx_sig}, 32'd1);
        wait_idle("t6_idle_to");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
